qpd_reference_nco: RTL and testbench

// Quadrature reference generator: the modulation end of the QPD lock-in chain. A phase

---
 rtl/qpd_reference_nco.sv | 195 +++++++++++++++++++
 tb/tb_qpd_reference_nco.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/qpd_reference_nco.sv
// Quadrature reference NCO: tick-driven phase accumulator feeding a quarter-wave sine LUT.
// Optional build macro QPD_NCO_AMPLITUDE_EN adds amp_i (Q0.16 gain) and one pipeline stage.

module qpd_nco_lane #(
   parameter int LUT_ADDR_BITS = 10,
   parameter int NUM_BITS_OUT  = 24
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic [LUT_ADDR_BITS+1:0]       ph,
`ifdef QPD_NCO_AMPLITUDE_EN
   input  logic [15:0]                    amp,
`endif
   output logic signed [NUM_BITS_OUT-1:0] val
);
   localparam int LA    = LUT_ADDR_BITS;
   localparam int LW    = NUM_BITS_OUT - 1;
   localparam int DEPTH = 1 << LA;

   // Entries sampled at bin centres, so the table never holds zero and folds symmetrically.
   function automatic logic [LW-1:0] lut_entry(input int k);
      real fs, x;
      fs = real'((longint'(1) << LW) - 1);
      x  = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(4 * DEPTH);
      return LW'($rtoi(fs * $sin(x) + 0.5));
   endfunction

   logic [LW-1:0] rom [DEPTH];
   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic [LW-1:0] ENTRY = lut_entry(k);
      assign rom[k] = ENTRY;
   end

   logic [LA-1:0] addr1;
   logic          neg1, neg2;
   logic [LW-1:0] mag2;
   logic [LW-1:0] mag_f;
   logic          neg_f;
   logic signed [NUM_BITS_OUT-1:0] pos;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         addr1 <= '0;
         neg1  <= 1'b0;
         mag2  <= '0;
         neg2  <= 1'b0;
      end else begin
         addr1 <= ph[LA] ? ~ph[LA-1:0] : ph[LA-1:0];
         neg1  <= ph[LA+1];
         mag2  <= rom[addr1];
         neg2  <= neg1;
      end
   end

`ifdef QPD_NCO_AMPLITUDE_EN
   logic [15:0]   amp2;
   logic [LW-1:0] mag3;
   logic          neg3;

   // Magnitude is scaled before the sign, so floor and negate stay symmetric.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         amp2 <= '0;
         mag3 <= '0;
         neg3 <= 1'b0;
      end else begin
         amp2 <= amp;
         mag3 <= LW'(({16'd0, mag2} * {{LW{1'b0}}, amp2}) >> 16);
         neg3 <= neg2;
      end
   end

   assign mag_f = mag3;
   assign neg_f = neg3;
`else
   assign mag_f = mag2;
   assign neg_f = neg2;
`endif

   assign pos = {1'b0, mag_f};
   assign val = neg_f ? -pos : pos;
endmodule

module qpd_reference_nco #(
   parameter int PHASE_BITS    = 32,
   parameter int LUT_ADDR_BITS = 10,
   parameter int NUM_BITS_OUT  = 24
) (
   input  logic                           clk_i,
   input  logic                           reset_ni,
   input  logic                           enable_i,
   input  logic                           tick_i,
   input  logic                           sync_i,
   input  logic [PHASE_BITS-1:0]          freq_i,
   input  logic                           freq_valid_i,
   output logic                           freq_ready_o,
`ifdef QPD_NCO_AMPLITUDE_EN
   input  logic [15:0]                    amp_i,
`endif
   output logic signed [NUM_BITS_OUT-1:0] sin_o,
   output logic signed [NUM_BITS_OUT-1:0] cos_o,
   output logic                           wrap_o,
   output logic                           done_o
);
   localparam int PB = PHASE_BITS;
   localparam int LA = LUT_ADDR_BITS;
   localparam int W  = NUM_BITS_OUT;
`ifdef QPD_NCO_AMPLITUDE_EN
   localparam int STAGES = 4;
`else
   localparam int STAGES = 3;
`endif

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state;
   logic [PB-1:0]   phase, freq_q, pend_q, inc, sum;
   logic            pend_vld, sync_q, carry, active, do_sync;
   logic [STAGES:0] vld_pipe, wrap_pipe;

   logic [1:0][LA+1:0] lane_ph;
   logic [1:0][W-1:0]  lane_val;

   assign active       = (state == RUN) && enable_i;
   assign do_sync      = sync_q | sync_i;
   assign inc          = pend_vld ? pend_q : freq_q;
   assign {carry, sum} = {1'b0, phase} + {1'b0, inc};
   assign freq_ready_o = ~pend_vld;
   assign done_o       = vld_pipe[STAGES];
   assign wrap_o       = wrap_pipe[STAGES];

   // Cosine is a quarter turn ahead: bump the quadrant field only.
   assign lane_ph[0] = phase[PB-1 -: LA+2];
   assign lane_ph[1] = {phase[PB-1 -: 2] + 2'd1, phase[PB-3 -: LA]};

   for (genvar i = 0; i < 2; i++) begin : g_lane
      qpd_nco_lane #(
         .LUT_ADDR_BITS (LA),
         .NUM_BITS_OUT  (W)
      ) u_lane (
         .clk_i    (clk_i),
         .reset_ni (reset_ni),
         .ph       (lane_ph[i]),
`ifdef QPD_NCO_AMPLITUDE_EN
         .amp      (amp_i),
`endif
         .val      (lane_val[i])
      );
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state     <= IDLE;
         phase     <= '0;
         freq_q    <= '0;
         pend_q    <= '0;
         pend_vld  <= 1'b0;
         sync_q    <= 1'b0;
         vld_pipe  <= '0;
         wrap_pipe <= '0;
         sin_o     <= '0;
         cos_o     <= '0;
      end else begin
         state <= enable_i ? RUN : IDLE;
         if (freq_valid_i && !pend_vld) begin
            pend_q   <= freq_i;
            pend_vld <= 1'b1;
         end
         if (sync_i) sync_q <= 1'b1;
         if (active) begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], tick_i};
            wrap_pipe <= {wrap_pipe[STAGES-1:0], tick_i & carry & ~do_sync};
            if (tick_i) begin
               phase  <= do_sync ? '0 : sum;
               sync_q <= 1'b0;
               if (pend_vld) begin
                  freq_q   <= pend_q;
                  pend_vld <= 1'b0;
               end
            end
            if (vld_pipe[STAGES-1]) begin
               sin_o <= lane_val[0];
               cos_o <= lane_val[1];
            end
         end else begin
            // Idle or leaving RUN: drop anything in flight and park at phase 0.
            vld_pipe  <= '0;
            wrap_pipe <= '0;
            phase     <= '0;
            sin_o     <= '0;
            cos_o     <= '0;
         end
      end
   end
endmodule

// File: tb/tb_qpd_reference_nco.sv
// Scoreboarded bench for qpd_reference_nco: directed vectors plus a phase sweep and its mirror.
module tb_qpd_reference_nco;
   localparam int FS = 8388607;
   localparam int N  = 1024;
   localparam logic [31:0] F = 32'h0123_4567;
`ifdef QPD_NCO_AMPLITUDE_EN
   localparam int  LAT = 4;
   localparam real AMP = 0.5;
`else
   localparam int  LAT = 3;
   localparam real AMP = 1.0;
`endif

   logic clk = 1'b0;
   logic reset_ni, enable_i, tick_i, sync_i, freq_valid_i, freq_ready_o, wrap_o, done_o;
   logic [31:0] freq_i;
   logic signed [23:0] sin_o, cos_o;
`ifdef QPD_NCO_AMPLITUDE_EN
   logic [15:0] amp_i = 16'h8000;
`endif

   qpd_reference_nco dut (
      .clk_i        (clk),
      .reset_ni     (reset_ni),
      .enable_i     (enable_i),
      .tick_i       (tick_i),
      .sync_i       (sync_i),
      .freq_i       (freq_i),
      .freq_valid_i (freq_valid_i),
      .freq_ready_o (freq_ready_o),
`ifdef QPD_NCO_AMPLITUDE_EN
      .amp_i        (amp_i),
`endif
      .sin_o        (sin_o),
      .cos_o        (cos_o),
      .wrap_o       (wrap_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          mode;   // 0 exact, 1 sweep (record), 2 mirror of sweep
      int          sin_v;
      int          cos_v;
      bit          wrap;
      int          cyc;
      logic [31:0] ph;
   } exp_t;

   exp_t sbq[$];
   int   rec_s[$];
   int   rec_c[$];
   int   mir_idx = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sc(int v);
`ifdef QPD_NCO_AMPLITUDE_EN
      return (v >= 0) ? v / 2 : -((-v) / 2);
`else
      return v;
`endif
   endfunction

   function automatic exp_t mk(int s, int c, bit w);
      exp_t e;
      e.mode = 0; e.sin_v = sc(s); e.cos_v = sc(c); e.wrap = w; e.cyc = 0; e.ph = '0;
      return e;
   endfunction

   task automatic check(string name, longint act, longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_tol(string name, longint act, longint req, longint tol);
      longint d;
      d = act - req;
      if (d < 0) d = -d;
      n_vec++;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d +/- %0d (cycle %0d)", name, act, req, tol, cyc);
      end
   endtask

   // Monitor: pops one expectation per done_o pulse.
   always @(negedge clk) begin
      if (done_o) begin
         if (sbq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done: got done_o=1, want 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            real  a;
            e = sbq.pop_front();
            check("done_latency", cyc, e.cyc);
            check("wrap", wrap_o, e.wrap);
            case (e.mode)
               0: begin
                  check("sin", sin_o, e.sin_v);
                  check("cos", cos_o, e.cos_v);
               end
               1: begin
                  a = 2.0 * 3.14159265358979323846 * real'(e.ph) / 4294967296.0;
                  check_tol("sweep_sin", sin_o, longint'(AMP * FS * $sin(a)), 6500);
                  check_tol("sweep_cos", cos_o, longint'(AMP * FS * $cos(a)), 6500);
                  check_tol("sweep_radius", longint'(sin_o) * sin_o + longint'(cos_o) * cos_o,
                            longint'((AMP * FS) * (AMP * FS)), 4 * longint'(FS));
                  rec_s.push_back(int'(sin_o));
                  rec_c.push_back(int'(cos_o));
               end
               default: begin
                  check_tol("mirror_sin", sin_o, -rec_s[mir_idx], 1);
                  check_tol("mirror_cos", cos_o, rec_c[mir_idx], 1);
                  mir_idx++;
               end
            endcase
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tick(input bit sy, input bit push, input exp_t e);
      tick_i = 1'b1; sync_i = sy;
      if (push) begin e.cyc = cyc + 1 + LAT; sbq.push_back(e); end
      step(1);
      tick_i = 1'b0; sync_i = 1'b0;
      step(5);
   endtask

   task automatic send_freq(input logic [31:0] f);
      int t;
      t = 0;
      freq_i = f; freq_valid_i = 1'b1;
      while (!freq_ready_o && t < 50) begin step(1); t++; end
      if (t == 50) check("freq_accept_timeout", 0, 1);
      step(1);
      freq_valid_i = 1'b0;
   endtask

   initial begin
      exp_t        e;
      logic [32:0] acc;
      int          t;
      reset_ni = 1'b0; enable_i = 1'b0; tick_i = 1'b0; sync_i = 1'b0;
      freq_valid_i = 1'b0; freq_i = '0;
      step(2);
      tick_i = 1'b1; enable_i = 1'b1; step(1); tick_i = 1'b0; step(4);
      check("rst_sin", sin_o, 0);
      check("rst_cos", cos_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ready", freq_ready_o, 1);
      enable_i = 1'b0;
      reset_ni = 1'b1; step(2);
      check("post_rst_sin", sin_o, 0);
      check("post_rst_ready", freq_ready_o, 1);

      // Quarter-turn steps; the increment is pending while IDLE.
      send_freq(32'h4000_0000);
      check("ready_drop", freq_ready_o, 0);
      enable_i = 1'b1; step(2);
      tick(0, 1, mk(8388605, -6434, 0));
      tick(0, 1, mk(-6434, -8388605, 0));
      tick(0, 1, mk(-8388605, 6434, 0));
      tick(0, 1, mk(6434, 8388605, 1));
      check("hold_sin", sin_o, sc(6434));
      check("ready_back", freq_ready_o, 1);

      // Update between ticks; a second update stalls until the first is applied.
      send_freq(32'h8000_0000);
      check("ready_drop_upd", freq_ready_o, 0);
      freq_i = 32'h4000_0000; freq_valid_i = 1'b1;
      step(2);
      check("stall_ready", freq_ready_o, 0);
      tick_i = 1'b1;
      e = mk(-6434, -8388605, 0); e.cyc = cyc + 1 + LAT; sbq.push_back(e);
      step(1);
      tick_i = 1'b0;
      check("ready_rise", freq_ready_o, 1);
      step(1);
      freq_valid_i = 1'b0;
      check("second_accept", freq_ready_o, 0);
      step(4);
      tick(0, 1, mk(-8388605, 6434, 0));

      // Sync: same-cycle and sticky.
      tick(0, 1, mk(6434, 8388605, 1));
      tick(1, 1, mk(6434, 8388605, 0));
      sync_i = 1'b1; step(1); sync_i = 1'b0; step(2);
      tick(0, 1, mk(6434, 8388605, 0));

      // Enable dropped one cycle after a tick discards that sample.
      tick_i = 1'b1; step(1);
      tick_i = 1'b0; enable_i = 1'b0; step(6);
      check("idle_sin", sin_o, 0);
      check("idle_cos", cos_o, 0);
      enable_i = 1'b1; step(2);
      tick(0, 1, mk(8388605, -6434, 0));

      // Sweep, then the same sweep with negated increment.
      send_freq(F);
      tick(1, 1, mk(6434, 8388605, 0));
      acc = '0;
      for (int k = 0; k < N; k++) begin
         acc = {1'b0, acc[31:0]} + {1'b0, F};
         e.mode = 1; e.sin_v = 0; e.cos_v = 0; e.wrap = acc[32]; e.ph = acc[31:0];
         tick(0, 1, e);
      end
      send_freq(-F);
      tick(1, 1, mk(6434, 8388605, 0));
      acc = '0;
      for (int k = 0; k < N; k++) begin
         acc = {1'b0, acc[31:0]} + {1'b0, -F};
         e.mode = 2; e.sin_v = 0; e.cos_v = 0; e.wrap = acc[32]; e.ph = acc[31:0];
         tick(0, 1, e);
      end

      t = 0;
      while (sbq.size() != 0 && t < 100) begin step(1); t++; end
      if (sbq.size() != 0) check("drain_pending", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
